i2c_target: RTL and testbench
=============================

// Module: i2c_target
// PURPOSE
//  I2C target (responder): the far end of the i2c_ctrl initiator on the same bus.
//  - Decodes START, repeated START and STOP; matches a 7-bit address.
//  - Receives write bytes into rx_data; serves read bytes from tx_data.
//  - Drives SDA open-drain, low or Z only. Never stretches SCL.
// PARAMETERS
//  ADDR         7'h42  7-bit target address; compared against address byte bits [7:1]
//  SYNC_STAGES  2      synchronizer flops on SDA/SCL inputs, minimum 2
// PORTS
//  clk        in     1  system clock, >= 10x SCL rate
//  rstn       in     1  asynchronous active-low reset
//  i2c_sda    inout  1  bus SDA; driven 1'b0 or 1'bz only
//  i2c_scl    in     1  bus SCL; sampled only
//  rx_ack_en  in     1  1: ACK received bytes; 0: NACK them; sampled when rx_valid fires
//  tx_data    in     8  next read byte; must be valid when tx_req pulses
//  rx_data    out    8  last received byte; holds until next rx_valid
//  rx_valid   out    1  1-cycle pulse, rx_data updated
//  tx_req     out    1  1-cycle pulse, tx_data captured into shifter; present next byte
//  tx_nack    out    1  1-cycle pulse, initiator NACKed a read byte (end of read)
//  addressed  out    1  high from address ACK until STOP or repeated START
//  rw         out    1  R/W bit of current transfer (1 = read); valid while addressed
//  start_det  out    1  1-cycle pulse per START or repeated START
//  stop_det   out    1  1-cycle pulse per STOP
// BEHAVIOUR
//  Reset: all outputs 0, rx_data 8'h00, SDA released, state IDLE. Reset mid-byte
//   releases SDA immediately and discards the partial byte.
//  Events (synchronized lines): scl_rise, scl_fall.
//   START = SDA fall while SCL high. STOP = SDA rise while SCL high.
//  Sampling and driving: sample SDA on scl_rise. Change the SDA drive only on
//   scl_fall, or on entering IDLE/WAIT_STOP. Hold time is the synchronizer
//   latency, SYNC_STAGES+1 clk cycles.
//  START from any state: release SDA, bitcnt=0, clear addressed, then go to ADDR.
//  STOP from any state: release SDA, clear addressed, then go to IDLE.
//  FSM (bitcnt is 3 bits and counts rises 0..7):
//   IDLE      wait for START.
//   ADDR      shift 8 bits MSB first. At the scl_fall after the 8th bit:
//             match: drive 0, latch rw, set addressed, go to ADDR_ACK.
//             mismatch: go to WAIT_STOP.
//   ADDR_ACK  at the next scl_fall, release SDA.
//             rw=0: go to RX.
//             rw=1: load tx_data, pulse tx_req, drive bit7 in the same cycle, go to TX.
//   RX        shift 8 bits. At the scl_fall after the 8th bit: update rx_data,
//             pulse rx_valid, drive 0 if rx_ack_en, go to RX_ACK.
//   RX_ACK    at the next scl_fall: release SDA, bitcnt=0, go to RX.
//   TX        drive bit[7-bitcnt] at each scl_fall. After the 8th bit, release SDA
//             at scl_fall and go to TX_ACK.
//   TX_ACK    sample SDA on scl_rise.
//             0: at the next scl_fall load tx_data, pulse tx_req, go to TX.
//             1: pulse tx_nack, go to WAIT_STOP.
//   WAIT_STOP SDA released; leave only on START or STOP.
//  Never drive a 1: a 1 bit is Z. A driven 0 is held through the SCL high phase.
//  START or STOP mid-byte (protocol violation): abort the byte. Do not pulse
//   rx_valid. Follow the START/STOP rule above.
//  Same-cycle START/STOP and an SCL edge is impossible (SCL high); STOP wins over
//   any pending FSM action.
// STRUCTURE
//  i2c_pkg: typedef enum i2c_tgt_state_t, START/STOP encodings, I2C_RW_READ=1.
//  Sub-module i2c_line_sync: SYNC_STAGES sync on both lines. Outputs:
//   scl_rise, scl_fall, start, stop, sda_s.
//  Top: FSM, bitcnt, 8-bit shifter, SDA tri-state assign.
// TESTING
//  1 Write 0x84 (addr 0x42,W), 0xA5, 0x3C, STOP -> ACK on the 3 9th clocks;
//    rx_valid x2 with 0xA5 then 0x3C; stop_det 1 pulse; addressed back to 0.
//  2 Address 0x86 (0x43) -> SDA never driven; all data pulses absent; WAIT_STOP until STOP.
//  3 Read 0x85; tx_data 0x5A, then 0xC3; initiator ACK then NACK -> bus sees 0x5A, 0xC3;
//    tx_req x2; tx_nack 1 pulse; SDA released before STOP.
//  4 Write 0x84, 0x11, repeated START, 0x85 read -> start_det x2; rw 0 then 1;
//    first tx_req follows the second address ACK.
//  5 rx_ack_en=0 during byte 0x77 -> SDA high at 9th clock; rx_valid still pulses, 0x77.
//  6 rstn low mid-TX while driving 0 -> SDA Z within 1 cycle; outputs 0; next START accepted.

Source files
------------

// File: rtl/i2c_pkg.sv
/******************************************************************************
 * Module   : i2c_pkg
 * Brief    : Shared types and encodings for the I2C target.
 * Revision : 1.0
 ******************************************************************************/
`default_nettype none

package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX        = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX        = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_tgt_state_t;

  // {previous SDA, current SDA} patterns while SCL stays high
  localparam logic [1:0] I2C_SDA_START = 2'b10;
  localparam logic [1:0] I2C_SDA_STOP  = 2'b01;

  localparam logic I2C_RW_READ = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_line_sync.sv
/******************************************************************************
 * Module   : i2c_line_sync
 * Brief    : Synchronizes SCL/SDA and derives edge, START and STOP events.
 * Revision : 1.0
 ******************************************************************************/
`default_nettype none

module i2c_line_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_s_o
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] scl_sync_q;
  logic [STAGES-1:0] sda_sync_q;
  logic              scl_prev_q;
  logic              sda_prev_q;
  logic              scl_s;
  logic              sda_s;

  // Reset to the idle-bus level so release of reset never looks like an event
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[STAGES-1];
  assign sda_s      = sda_sync_q[STAGES-1];
  assign sda_s_o    = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  assign start_o    = scl_s & scl_prev_q & ({sda_prev_q, sda_s} == I2C_SDA_START);
  assign stop_o     = scl_s & scl_prev_q & ({sda_prev_q, sda_s} == I2C_SDA_STOP);

endmodule

`default_nettype wire

// File: rtl/i2c_target.sv
/******************************************************************************
 * Module   : i2c_target
 * Brief    : I2C target with 7-bit address match, byte RX/TX, open-drain SDA.
 * Revision : 1.0
 ******************************************************************************/
`default_nettype none

module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  inout  wire        i2c_sda,
  input  logic       i2c_scl,
  input  logic       rx_ack_en,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       tx_nack,
  output logic       addressed,
  output logic       rw,
  output logic       start_det,
  output logic       stop_det
);

  logic scl_rise, scl_fall, start_ev, stop_ev, sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rstn       (rstn),
    .scl_i      (i2c_scl),
    .sda_i      (i2c_sda),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_ev),
    .stop_o     (stop_ev),
    .sda_s_o    (sda_s)
  );

  i2c_tgt_state_t state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  // full_q: all 8 bits of a byte seen (or ACK seen in TX_ACK), awaiting the fall
  logic       full_q, full_d;
  logic       sda_oe_q, sda_oe_d;
  logic       addressed_q, addressed_d;
  logic       rw_q, rw_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       tx_nack_q, tx_nack_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      full_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      tx_nack_q   <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      full_q      <= full_d;
      sda_oe_q    <= sda_oe_d;
      addressed_q <= addressed_d;
      rw_q        <= rw_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      tx_nack_q   <= tx_nack_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    full_d      = full_q;
    sda_oe_d    = sda_oe_q;
    addressed_d = addressed_q;
    rw_d        = rw_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    tx_nack_d   = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;

    if (stop_ev) begin
      stop_d      = 1'b1;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      full_d      = 1'b0;
      state_d     = ST_IDLE;
    end else if (start_ev) begin
      start_d     = 1'b1;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
      bitcnt_d    = 3'd0;
      full_d      = 1'b0;
      state_d     = ST_ADDR;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_ADDR, ST_RX: begin
          if (scl_rise && !full_q) begin
            shift_d  = {shift_q[6:0], sda_s};
            bitcnt_d = bitcnt_q + 3'd1;
            full_d   = (bitcnt_q == 3'd7);
          end
          if (scl_fall && full_q) begin
            full_d = 1'b0;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == ADDR) begin
                sda_oe_d    = 1'b1;
                rw_d        = shift_q[0];
                addressed_d = 1'b1;
                state_d     = ST_ADDR_ACK;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = ST_WAIT_STOP;
              end
            end else begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = rx_ack_en;
              state_d    = ST_RX_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bitcnt_d = 3'd0;
            if (rw_q == I2C_RW_READ) begin
              shift_d  = tx_data;
              tx_req_d = 1'b1;
              sda_oe_d = ~tx_data[7];
              state_d  = ST_TX;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_RX;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            bitcnt_d = 3'd0;
            state_d  = ST_RX;
          end
        end
        ST_TX: begin
          if (scl_rise && !full_q) begin
            bitcnt_d = bitcnt_q + 3'd1;
            full_d   = (bitcnt_q == 3'd7);
          end
          if (scl_fall) begin
            if (full_q) begin
              full_d   = 1'b0;
              sda_oe_d = 1'b0;
              state_d  = ST_TX_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise && !full_q) begin
            if (sda_s) begin
              tx_nack_d = 1'b1;
              sda_oe_d  = 1'b0;
              state_d   = ST_WAIT_STOP;
            end else begin
              full_d = 1'b1;
            end
          end
          if (scl_fall && full_q) begin
            full_d   = 1'b0;
            bitcnt_d = 3'd0;
            shift_d  = tx_data;
            tx_req_d = 1'b1;
            sda_oe_d = ~tx_data[7];
            state_d  = ST_TX;
          end
        end
        ST_WAIT_STOP: sda_oe_d = 1'b0;
        default: begin
          sda_oe_d = 1'b0;
          state_d  = ST_IDLE;
        end
      endcase
    end
  end

  assign i2c_sda   = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign tx_nack   = tx_nack_q;
  assign addressed = addressed_q;
  assign rw        = rw_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
/******************************************************************************
 * Module   : tb_i2c_target
 * Brief    : Directed self-checking bench acting as I2C initiator.
 * Revision : 1.0
 ******************************************************************************/
`default_nettype none

module tb_i2c_target;

  localparam time TQ = 100ns;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       scl = 1'b1;
  logic       tb_sda_low = 1'b0;
  logic       rx_ack_en = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, tx_nack, addressed, rw, start_det, stop_det;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = tb_sda_low ? 1'b0 : 1'bz;

  always #5ns clk = ~clk;

  i2c_target #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i2c_sda   (sda_bus),
    .i2c_scl   (scl),
    .rx_ack_en (rx_ack_en),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_req    (tx_req),
    .tx_nack   (tx_nack),
    .addressed (addressed),
    .rw        (rw),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  int total = 0;
  int bad = 0;

  // Cumulative event counters; tests compare deltas
  int         n_rxv = 0, n_txr = 0, n_nack = 0, n_start = 0, n_stop = 0, n_low = 0;
  logic [7:0] rx_log [0:31];

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[n_rxv[4:0]] = rx_data;
      n_rxv++;
    end
    if (tx_req)    n_txr++;
    if (tx_nack)   n_nack++;
    if (start_det) n_start++;
    if (stop_det)  n_stop++;
    if (!tb_sda_low && sda_bus === 1'b0) n_low++;
  end

  task automatic bus_start();
    tb_sda_low = 1'b0; scl = 1'b1; #TQ;
    tb_sda_low = 1'b1; #TQ;
    scl = 1'b0; #TQ;
  endtask

  task automatic bus_rstart();
    tb_sda_low = 1'b0; #TQ;
    scl = 1'b1; #TQ;
    tb_sda_low = 1'b1; #TQ;
    scl = 1'b0; #TQ;
  endtask

  task automatic bus_stop();
    tb_sda_low = 1'b1; #TQ;
    scl = 1'b1; #TQ;
    tb_sda_low = 1'b0; #TQ;
  endtask

  task automatic write_bit(input logic b);
    tb_sda_low = ~b; #TQ;
    scl = 1'b1; #(2*TQ);
    scl = 1'b0; #TQ;
  endtask

  task automatic read_bit(output logic b);
    tb_sda_low = 1'b0; #TQ;
    scl = 1'b1; #TQ;
    b = (sda_bus === 1'b0) ? 1'b0 : 1'b1;
    #TQ;
    scl = 1'b0; #TQ;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ackbit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(ackbit);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({rx_data, rx_valid, tx_req, tx_nack, addressed, rw, start_det, stop_det} !== 15'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0",
               {rx_data, rx_valid, tx_req, tx_nack, addressed, rw, start_det, stop_det});
    end
    total++;
    if (sda_bus !== 1'b1) begin
      bad++; $display("FAIL reset_sda got=%b exp=1", sda_bus);
    end
    rstn = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int b_rxv = n_rxv, b_stop = n_stop, b_start = n_start;
    bus_start();
    write_byte(8'h84, a0);
    total++;
    if (addressed !== 1'b1 || rw !== 1'b0) begin
      bad++; $display("FAIL wr_addressed got=%b rw=%b exp=1 rw=0", addressed, rw);
    end
    write_byte(8'hA5, a1);
    write_byte(8'h3C, a2);
    bus_stop();
    total++;
    if ({a0, a1, a2} !== 3'b000) begin
      bad++; $display("FAIL wr_acks got=%b exp=000", {a0, a1, a2});
    end
    total++;
    if (n_rxv - b_rxv !== 2) begin
      bad++; $display("FAIL wr_rx_valid_cnt got=%0d exp=2", n_rxv - b_rxv);
    end
    total++;
    if (rx_log[b_rxv[4:0]] !== 8'hA5 || rx_log[b_rxv[4:0] + 5'd1] !== 8'h3C) begin
      bad++; $display("FAIL wr_rx_data got=%h,%h exp=a5,3c",
                      rx_log[b_rxv[4:0]], rx_log[b_rxv[4:0] + 5'd1]);
    end
    total++;
    if (n_stop - b_stop !== 1 || n_start - b_start !== 1) begin
      bad++; $display("FAIL wr_start_stop got=%0d,%0d exp=1,1", n_start - b_start, n_stop - b_stop);
    end
    total++;
    if (addressed !== 1'b0) begin
      bad++; $display("FAIL wr_addressed_after_stop got=%b exp=0", addressed);
    end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    int b_rxv = n_rxv, b_txr = n_txr, b_low = n_low, b_stop = n_stop;
    bus_start();
    write_byte(8'h86, a0);
    write_byte(8'h55, a1);
    total++;
    if ({a0, a1} !== 2'b11 || n_low - b_low !== 0) begin
      bad++; $display("FAIL nomatch_sda got=acks %b lowcnt %0d exp=11 0", {a0, a1}, n_low - b_low);
    end
    total++;
    if (addressed !== 1'b0 || n_rxv - b_rxv !== 0 || n_txr - b_txr !== 0) begin
      bad++; $display("FAIL nomatch_pulses got=addr %b rxv %0d txr %0d exp=0 0 0",
                      addressed, n_rxv - b_rxv, n_txr - b_txr);
    end
    bus_stop();
    total++;
    if (n_stop - b_stop !== 1) begin
      bad++; $display("FAIL nomatch_stop got=%0d exp=1", n_stop - b_stop);
    end
  endtask

  task automatic test_read();
    logic a0, rel;
    logic [7:0] d0, d1;
    int b_txr = n_txr, b_nack = n_nack;
    tx_data = 8'h5A;
    bus_start();
    write_byte(8'h85, a0);
    #TQ;
    total++;
    if (a0 !== 1'b0 || n_txr - b_txr !== 1 || rw !== 1'b1) begin
      bad++; $display("FAIL rd_addr got=ack %b txr %0d rw %b exp=0 1 1", a0, n_txr - b_txr, rw);
    end
    tx_data = 8'hC3;
    #TQ;
    read_byte(d0, 1'b0);
    read_byte(d1, 1'b1);
    total++;
    if (d0 !== 8'h5A || d1 !== 8'hC3) begin
      bad++; $display("FAIL rd_data got=%h,%h exp=5a,c3", d0, d1);
    end
    total++;
    if (n_txr - b_txr !== 2 || n_nack - b_nack !== 1) begin
      bad++; $display("FAIL rd_pulses got=txr %0d nack %0d exp=2 1", n_txr - b_txr, n_nack - b_nack);
    end
    tb_sda_low = 1'b0;
    #TQ;
    rel = sda_bus;
    total++;
    if (rel !== 1'b1) begin
      bad++; $display("FAIL rd_release got=%b exp=1", rel);
    end
    bus_stop();
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2;
    logic [7:0] d0;
    int b_start = n_start, b_txr = n_txr, b_rxv = n_rxv;
    tx_data = 8'hE7;
    bus_start();
    write_byte(8'h84, a0);
    total++;
    if (rw !== 1'b0 || addressed !== 1'b1) begin
      bad++; $display("FAIL b2b_rw_first got=rw %b addr %b exp=0 1", rw, addressed);
    end
    write_byte(8'h11, a1);
    bus_rstart();
    total++;
    if (addressed !== 1'b0 || n_txr - b_txr !== 0 || rx_log[b_rxv[4:0]] !== 8'h11) begin
      bad++; $display("FAIL b2b_rstart got=addr %b txr %0d rx %h exp=0 0 11",
                      addressed, n_txr - b_txr, rx_log[b_rxv[4:0]]);
    end
    write_byte(8'h85, a2);
    #TQ;
    total++;
    if (rw !== 1'b1 || n_start - b_start !== 2 || n_txr - b_txr !== 1 || {a0, a1, a2} !== 3'b000) begin
      bad++; $display("FAIL b2b_second got=rw %b starts %0d txr %0d acks %b exp=1 2 1 000",
                      rw, n_start - b_start, n_txr - b_txr, {a0, a1, a2});
    end
    #TQ;
    read_byte(d0, 1'b1);
    total++;
    if (d0 !== 8'hE7) begin
      bad++; $display("FAIL b2b_read got=%h exp=e7", d0);
    end
    bus_stop();
  endtask

  task automatic test_nack_rx();
    logic a0, a1;
    int b_rxv = n_rxv;
    rx_ack_en = 1'b0;
    bus_start();
    write_byte(8'h84, a0);
    write_byte(8'h77, a1);
    total++;
    if (a0 !== 1'b0 || a1 !== 1'b1) begin
      bad++; $display("FAIL nack_rx_acks got=%b%b exp=01", a0, a1);
    end
    total++;
    if (n_rxv - b_rxv !== 1 || rx_data !== 8'h77) begin
      bad++; $display("FAIL nack_rx_data got=cnt %0d data %h exp=1 77", n_rxv - b_rxv, rx_data);
    end
    bus_stop();
    rx_ack_en = 1'b1;
  endtask

  task automatic test_reset_mid_tx();
    logic a0, a1, a2;
    logic drv;
    int b_rxv;
    tx_data = 8'h00;
    bus_start();
    write_byte(8'h85, a0);
    #TQ;
    drv = sda_bus;
    total++;
    if (a0 !== 1'b0 || drv !== 1'b0) begin
      bad++; $display("FAIL rst_tx_driving got=ack %b sda %b exp=0 0", a0, drv);
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    total++;
    if (sda_bus !== 1'b1) begin
      bad++; $display("FAIL rst_tx_sda got=%b exp=1", sda_bus);
    end
    total++;
    if ({rx_data, addressed, rw, tx_req, rx_valid} !== 12'h0) begin
      bad++; $display("FAIL rst_tx_outputs got=%h exp=0", {rx_data, addressed, rw, tx_req, rx_valid});
    end
    repeat (3) @(posedge clk);
    rstn = 1'b1;
    #TQ;
    scl = 1'b1;
    #(2*TQ);
    b_rxv = n_rxv;
    bus_start();
    write_byte(8'h84, a1);
    write_byte(8'h9E, a2);
    bus_stop();
    total++;
    if ({a1, a2} !== 2'b00 || n_rxv - b_rxv !== 1 || rx_data !== 8'h9E) begin
      bad++; $display("FAIL rst_tx_recover got=acks %b cnt %0d data %h exp=00 1 9e",
                      {a1, a2}, n_rxv - b_rxv, rx_data);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_back_to_back();
    test_nack_rx();
    test_reset_mid_tx();
    #(4*TQ);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
